// File: rtl/periph_sel_ctrl_pkg.sv
// Shared definitions for the peripheral select controller: FSM encoding and default window/timeout.
package periph_sel_ctrl_pkg;

    localparam logic [31:0] PSC_BASE_ADDR = 32'h1A10_0000;
    localparam int unsigned PSC_TIMEOUT   = 16;
    localparam int unsigned PSC_WAIT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_DECERR = 3'd4
    } psc_state_t;

endpackage

// File: rtl/periph_sel_ctrl.sv
// Bridges single core requests onto a two-phase peripheral bus with a 256-way select index,
// address decode error and bounded wait-state timeout.
module periph_sel_ctrl
    import periph_sel_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = PSC_BASE_ADDR,
    parameter int unsigned TIMEOUT   = PSC_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [7:0]  psel_idx_o,
    output logic        psel_en_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [7:0]  paddr_o,
    output logic [31:0] pwdata_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    // Last wait count value that may still be spent in ACCESS.
    localparam logic [PSC_WAIT_W-1:0] WAIT_LAST = PSC_WAIT_W'(TIMEOUT - 1);

    psc_state_t            r_state;
    psc_state_t            w_state_nxt;
    logic [PSC_WAIT_W-1:0] r_wait;
    logic [PSC_WAIT_W-1:0] w_wait_nxt;
    logic [7:0]            r_psel_idx;
    logic [7:0]            r_paddr;
    logic                  r_pwrite;
    logic [31:0]           r_pwdata;
    logic                  r_psel_en;
    logic                  r_penable;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_psel_en_nxt;
    logic                  w_penable_nxt;
    logic                  w_rvalid_nxt;
    logic [31:0]           w_rdata_nxt;
    logic                  w_err_nxt;

    assign w_in_range = (addr_i[31:16] == BASE_ADDR[31:16]);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant, and next values of the registered outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        gnt_o         = 1'b0;
        w_accept      = 1'b0;
        w_psel_en_nxt = 1'b0;
        w_penable_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
        w_rdata_nxt   = 32'h0;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    w_accept = 1'b1;
                    if (w_in_range) begin
                        w_state_nxt   = ST_SETUP;
                        w_wait_nxt    = '0;
                        w_psel_en_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_DECERR;
                        w_rvalid_nxt = 1'b1;
                        w_err_nxt    = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_psel_en_nxt = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    // A ready slave wins over a timeout reached in the same cycle.
                    w_state_nxt  = ST_RESP;
                    w_rvalid_nxt = 1'b1;
                    w_rdata_nxt  = r_pwrite ? 32'h0 : prdata_i;
                    w_err_nxt    = pslverr_i;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt  = ST_RESP;
                    w_rvalid_nxt = 1'b1;
                    w_err_nxt    = 1'b1;
                end else begin
                    w_wait_nxt    = r_wait + PSC_WAIT_W'(1);
                    w_psel_en_nxt = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            ST_RESP:   w_state_nxt = ST_IDLE;
            ST_DECERR: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered bus controls, response and wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait    <= '0;
            r_psel_en <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            r_wait    <= w_wait_nxt;
            r_psel_en <= w_psel_en_nxt;
            r_penable <= w_penable_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Request fields, captured only at accept so they hold through the whole transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_psel_idx <= 8'h0;
            r_paddr    <= 8'h0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= 32'h0;
        end else if (w_accept) begin
            r_psel_idx <= addr_i[15:8];
            r_paddr    <= addr_i[7:0];
            r_pwrite   <= we_i;
            r_pwdata   <= wdata_i;
        end
    end

    assign rvalid_o   = r_rvalid;
    assign rdata_o    = r_rdata;
    assign err_o      = r_err;
    assign psel_idx_o = r_psel_idx;
    assign psel_en_o  = r_psel_en;
    assign penable_o  = r_penable;
    assign pwrite_o   = r_pwrite;
    assign paddr_o    = r_paddr;
    assign pwdata_o   = r_pwdata;

endmodule

// File: tb/tb_periph_sel_ctrl.sv
// Directed bench for periph_sel_ctrl with hand-computed expectations.
module tb_periph_sel_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [7:0]  psel_idx_o;
    logic        psel_en_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [7:0]  paddr_o;
    logic [31:0] pwdata_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int n_checks = 0;
    int n_fail   = 0;

    periph_sel_ctrl dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .psel_idx_o (psel_idx_o),
        .psel_en_o  (psel_en_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .paddr_o    (paddr_o),
        .pwdata_o   (pwdata_o),
        .pready_i   (pready_i),
        .prdata_i   (prdata_i),
        .pslverr_i  (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one request and follows it to its response; req_i stays high with a different
    // address while busy to show it is ignored. Latency counts cycles after the accept cycle.
    task automatic xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input int waits, input logic [31:0] prd, input logic slv,
                        output int lat, output int n_acc, output int n_setup,
                        output logic saw_sel, output logic [31:0] rd, output logic er);
        req_i   = 1'b1;
        addr_i  = addr;
        we_i    = we;
        wdata_i = wd;
        #1;
        chk_eq("accept_gnt", 64'(gnt_o), 64'd1);
        lat     = -1;
        n_acc   = 0;
        n_setup = 0;
        saw_sel = 1'b0;
        rd      = 32'h0;
        er      = 1'b0;
        tick();
        addr_i  = ~addr;
        we_i    = ~we;
        wdata_i = ~wd;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            pready_i  = 1'b0;
            prdata_i  = ~prd;
            pslverr_i = ~slv;
            #1;
            chk_eq("busy_no_gnt", 64'(gnt_o), 64'd0);
            if (psel_en_o) saw_sel = 1'b1;
            if (rvalid_o) begin
                lat = cyc;
                rd  = rdata_o;
                er  = err_o;
                chk_eq("resp_no_sel", 64'({psel_en_o, penable_o}), 64'd0);
                break;
            end
            chk_eq("quiet_resp_zero", 64'({rdata_o, err_o}), 64'd0);
            if (psel_en_o && !penable_o) n_setup++;
            if (penable_o) begin
                chk_eq("access_hold", 64'({psel_idx_o, paddr_o, pwrite_o, pwdata_o}),
                       64'({addr[15:8], addr[7:0], we, wd}));
                if (n_acc == waits) begin
                    pready_i  = 1'b1;
                    prdata_i  = prd;
                    pslverr_i = slv;
                end
                n_acc++;
            end
            tick();
        end
        req_i     = 1'b0;
        addr_i    = 32'h0;
        we_i      = 1'b0;
        wdata_i   = 32'h0;
        pready_i  = 1'b0;
        prdata_i  = 32'h0;
        pslverr_i = 1'b0;
        if (lat < 0) chk_eq("resp_seen", 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n_acc;
        int          n_setup;
        logic        saw_sel;
        logic [31:0] rd;
        logic        er;
        logic [11:0] g_seq;
        logic [11:0] v_seq;

        rst_i = 1'b1; req_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; wdata_i = 32'h0;
        pready_i = 1'b0; prdata_i = 32'h0; pslverr_i = 1'b0;
        tick();
        tick();
        chk_eq("rst_ctrl", 64'({rvalid_o, err_o, psel_en_o, penable_o, pwrite_o}), 64'd0);
        chk_eq("rst_data", 64'({rdata_o, pwdata_o}), 64'd0);
        chk_eq("rst_addr", 64'({psel_idx_o, paddr_o}), 64'd0);
        rst_i = 1'b0;
        tick();

        // Zero-wait read.
        xfer(32'h1A10_0304, 1'b0, 32'h0, 0, 32'hCAFE_0001, 1'b0, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("rd_lat", 64'(lat), 64'd3);
        chk_eq("rd_setup", 64'(n_setup), 64'd1);
        chk_eq("rd_acc", 64'(n_acc), 64'd1);
        chk_eq("rd_data", 64'(rd), 64'hCAFE_0001);
        chk_eq("rd_err", 64'(er), 64'd0);
        chk_eq("rd_idx", 64'({psel_idx_o, paddr_o}), 64'h0304);
        tick();
        chk_eq("rd_after", 64'({rvalid_o, rdata_o, err_o}), 64'd0);

        // Write with three wait states.
        xfer(32'h1A10_FF10, 1'b1, 32'h1234_5678, 3, 32'hBEEF_0000, 1'b0, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("wr_lat", 64'(lat), 64'd6);
        chk_eq("wr_acc", 64'(n_acc), 64'd4);
        chk_eq("wr_data", 64'(rd), 64'd0);
        chk_eq("wr_err", 64'(er), 64'd0);
        chk_eq("wr_idx", 64'({psel_idx_o, paddr_o}), 64'hFF10);
        tick();

        // Out-of-window access.
        xfer(32'h2000_0000, 1'b0, 32'h0, 0, 32'h5555_5555, 1'b0, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("dec_lat", 64'(lat), 64'd1);
        chk_eq("dec_sel", 64'(saw_sel), 64'd0);
        chk_eq("dec_err", 64'(er), 64'd1);
        chk_eq("dec_data", 64'(rd), 64'd0);
        tick();

        // Slave never ready: forced error after 16 ACCESS cycles.
        xfer(32'h1A10_0100, 1'b0, 32'h0, -1, 32'hDEAD_BEEF, 1'b0, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("tmo_lat", 64'(lat), 64'd18);
        chk_eq("tmo_acc", 64'(n_acc), 64'd16);
        chk_eq("tmo_err", 64'(er), 64'd1);
        chk_eq("tmo_data", 64'(rd), 64'd0);
        tick();

        // Ready on the timeout cycle completes normally.
        xfer(32'h1A10_0220, 1'b0, 32'h0, 15, 32'h5A5A_0F0F, 1'b0, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("edge_lat", 64'(lat), 64'd18);
        chk_eq("edge_acc", 64'(n_acc), 64'd16);
        chk_eq("edge_err", 64'(er), 64'd0);
        chk_eq("edge_data", 64'(rd), 64'h5A5A_0F0F);
        tick();

        // Slave error with one wait state.
        xfer(32'h1A10_4488, 1'b0, 32'h0, 1, 32'h1111_2222, 1'b1, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("slv_lat", 64'(lat), 64'd4);
        chk_eq("slv_err", 64'(er), 64'd1);
        chk_eq("slv_data", 64'(rd), 64'h1111_2222);
        tick();

        // Reset in the middle of ACCESS.
        req_i = 1'b1; addr_i = 32'h1A10_0508; we_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
        #1;
        chk_eq("mid_gnt", 64'(gnt_o), 64'd1);
        tick();
        req_i = 1'b0;
        tick();
        chk_eq("mid_access", 64'({psel_en_o, penable_o}), 64'b11);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_eq("mid_rst_ctrl", 64'({psel_en_o, penable_o, rvalid_o, pwrite_o}), 64'd0);
        chk_eq("mid_rst_regs", 64'({psel_idx_o, paddr_o, pwdata_o}), 64'd0);
        v_seq = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            v_seq[i] = rvalid_o | psel_en_o;
        end
        chk_eq("mid_quiet", 64'(v_seq), 64'd0);
        xfer(32'h1A10_0304, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, lat, n_acc, n_setup, saw_sel, rd, er);
        chk_eq("post_rst_lat", 64'(lat), 64'd3);
        chk_eq("post_rst_data", 64'(rd), 64'h0BAD_F00D);
        tick();

        // Request held high back-to-back, in window, always ready.
        req_i = 1'b1; addr_i = 32'h1A10_0200; we_i = 1'b0; pready_i = 1'b1; prdata_i = 32'h77;
        g_seq = '0; v_seq = '0;
        for (int i = 0; i < 12; i++) begin
            #1;
            g_seq[i] = gnt_o;
            v_seq[i] = rvalid_o;
            tick();
        end
        chk_eq("b2b_gnt", 64'(g_seq), 64'h111);
        chk_eq("b2b_rvalid", 64'(v_seq), 64'h888);

        // Request held high back-to-back, out of window.
        addr_i = 32'h3000_0000; pready_i = 1'b0;
        g_seq = '0; v_seq = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            g_seq[i] = gnt_o;
            v_seq[i] = rvalid_o & err_o;
            tick();
        end
        chk_eq("b2b_dec_gnt", 64'(g_seq), 64'h55);
        chk_eq("b2b_dec_err", 64'(v_seq), 64'hAA);
        req_i = 1'b0; addr_i = 32'h0; prdata_i = 32'h0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_sel_ctrl.md
PERIPH_SEL_CTRL -- requirements
Module: periph_sel_ctrl

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 32'h1A10_0000, 64 KB peripheral window base, bits [15:0] ignored; TIMEOUT, 16, maximum ACCESS cycles before forced error completion, legal range 2..255.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 req_i  in  1  core request valid; addr_i in 32 request address; we_i in 1 write; wdata_i in 32 write data.
REQ-005 gnt_o  out  1  request accepted; rvalid_o out 1 response valid, one-cycle pulse; rdata_o out 32 read data; err_o out 1 response error, qualified by rvalid_o.
REQ-006 psel_idx_o  out  8  peripheral index, drives the 8-to-256 select decoder; psel_en_o out 1 qualifies the decoded select.
REQ-007 penable_o out 1; pwrite_o out 1; paddr_o out 8 byte offset in window; pwdata_o out 32.
REQ-008 pready_i in 1; prdata_i in 32; pslverr_i in 1.

Function
REQ-009 FSM states SHALL be IDLE, SETUP, ACCESS, RESP, DECERR.
REQ-010 IDLE: gnt_o = req_i, combinational; every other state drives gnt_o = 0.
REQ-011 At an IDLE accept, the block SHALL register addr_i[15:8] into psel_idx_o, addr_i[7:0] into paddr_o, we_i into pwrite_o, and wdata_i into pwdata_o.
REQ-012 At an IDLE accept, in-range (addr_i[31:16] == BASE_ADDR[31:16]) SHALL go to SETUP; out-of-range SHALL go to DECERR.
REQ-013 SETUP: psel_en_o=1, penable_o=0, lasts exactly one cycle, then goes to ACCESS.
REQ-014 ACCESS: psel_en_o=1, penable_o=1; psel_idx_o, paddr_o, pwrite_o and pwdata_o SHALL hold stable until ACCESS is left.
REQ-015 ACCESS with pready_i=1 SHALL capture prdata_i (reads only; writes capture 32'h0) and pslverr_i, then go to RESP.
REQ-016 An 8-bit wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready_i=0.
REQ-017 When the wait counter reaches TIMEOUT-1 with pready_i=0, the block SHALL go to RESP with err=1 and rdata=32'h0.
REQ-018 If pready_i=1 in the same cycle the timeout is reached, pready_i SHALL win and complete normally.
REQ-019 RESP: rvalid_o=1 for one cycle with the captured rdata/err, psel_en_o=0, penable_o=0, then go to IDLE.
REQ-020 DECERR: rvalid_o=1, err_o=1, rdata_o=32'h0 for one cycle; no peripheral select; then go to IDLE.
REQ-021 Latency, in-range, zero-wait SHALL be: accept cycle N, SETUP N+1, ACCESS N+2, rvalid_o N+3; out-of-range SHALL give rvalid_o at N+1.
REQ-022 req_i during SETUP/ACCESS/RESP/DECERR SHALL be ignored (no grant); a new request is accepted no earlier than the first IDLE cycle after RESP/DECERR.
REQ-023 rdata_o and err_o SHALL be 0 whenever rvalid_o=0.

Reset
REQ-024 rst_i=1 SHALL force IDLE and clear wait counter, psel_idx_o, paddr_o, pwdata_o, pwrite_o, psel_en_o, penable_o, rvalid_o, rdata_o and err_o to 0.
REQ-025 Reset during SETUP or ACCESS SHALL abandon the transfer with no response; psel_en_o and penable_o SHALL be 0 on the first cycle after reset.

Structure
REQ-026 The FSM state encoding and the default BASE_ADDR/TIMEOUT constants SHALL live in the shared SoC package.
REQ-027 The block SHALL be self-contained; the 8-to-256 decoder is instantiated by the parent and fed from psel_idx_o and psel_en_o.

Verification
REQ-028 Read 0x1A10_0304, pready_i=1 in first ACCESS, prdata_i=0xCAFE_0001 -> psel_idx_o=0x03, paddr_o=0x04, rvalid_o at N+3, rdata_o=0xCAFE_0001, err_o=0.
REQ-029 Write 0x1A10_FF10 with wdata 0x1234_5678, pready_i low 3 cycles -> pwdata_o stable across ACCESS, psel_idx_o=0xFF, rvalid_o at N+6, rdata_o=0.
REQ-030 Access 0x2000_0000 -> no psel_en_o, rvalid_o at N+1 with err_o=1.
REQ-031 pready_i held 0 -> err_o=1 after exactly TIMEOUT ACCESS cycles; separately, pready_i=1 on the timeout cycle -> err_o=pslverr_i=0.
REQ-032 rst_i asserted mid-ACCESS -> psel_en_o=0, penable_o=0, no rvalid_o; the next request completes normally.
REQ-033 req_i held high back-to-back -> exactly one gnt_o per transaction, next gnt_o in the cycle after RESP.
